// File: rtl/btn_clk_conditioner.sv
// btn_clk_conditioner: slow sampling/scan clock dividers plus four-channel button debouncer
module btn_clk_conditioner #(
  parameter int CNT_W  = 31,
  parameter int SCAN_W = 32,
  parameter int DB_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] div_offset,
  input  logic [4:0]       scan_sel,
  input  logic [3:0]       btns,
  output logic             slow_clk,
  output logic             disp_clk,
  output logic [1:0]       btn_pulse,
  output logic [1:0]       btn_level
);
  logic [CNT_W-1:0]  div_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  logic              slow_clk_q, slow_rise;
  logic [3:0]        s1, s2, db, set;
  logic [DB_LEN-1:0] sr [4];
  logic [DB_LEN-1:0] sr_next [4];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      slow_clk   <= 1'b0;
      slow_clk_q <= 1'b0;
      scan_cnt   <= '0;
      s1         <= '0;
      s2         <= '0;
    end else begin
      div_cnt    <= (div_cnt >= div_offset) ? '0 : div_cnt + CNT_W'(1);
      slow_clk   <= (div_cnt >= div_offset) ? ~slow_clk : slow_clk;
      slow_clk_q <= slow_clk;
      scan_cnt   <= scan_cnt + SCAN_W'(1);
      s1         <= btns;
      s2         <= s1;
    end
  end
  assign slow_rise = slow_clk & ~slow_clk_q;
  assign disp_clk  = scan_cnt[scan_sel];
  assign btn_level = db[3:2];
  for (genvar i = 0; i < 4; i++) begin : g_ch
    assign sr_next[i] = {sr[i][DB_LEN-2:0], s2[i]};
    assign set[i]     = &sr_next[i];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr[i] <= '0;
        db[i] <= 1'b0;
      end else if (slow_rise) begin
        sr[i] <= sr_next[i];
        db[i] <= set[i] ? 1'b1 : (~|sr_next[i]) ? 1'b0 : db[i];
      end
    end
  end
  // Pulse is registered alongside db so it lands in the same clk db rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_pulse <= '0;
    else        btn_pulse <= slow_rise ? (set[1:0] & ~db[1:0]) : 2'b00;
  end
endmodule

// File: tb/tb_btn_clk_conditioner.sv
// tb_btn_clk_conditioner: randomized + directed checks against a sample-run reference model
module tb_btn_clk_conditioner;
  localparam int CNT_W = 31, DB_LEN = 3;
  logic             clk = 1'b0, rst_n = 1'b0;
  logic [CNT_W-1:0] div_offset = '0;
  logic [4:0]       scan_sel = 5'd2;
  logic [3:0]       btns = '0;
  logic             slow_clk, disp_clk;
  logic [1:0]       btn_pulse, btn_level;
  int total = 0, bad = 0;
  int d, m, pulses0;
  int ones [4], zeros [4];
  logic [3:0] b1, b2, db, pulse;

  btn_clk_conditioner dut (
    .clk(clk), .rst_n(rst_n), .div_offset(div_offset), .scan_sel(scan_sel), .btns(btns),
    .slow_clk(slow_clk), .disp_clk(disp_clk), .btn_pulse(btn_pulse), .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got=%0h exp=%0h", tag, m, got, exp);
    end
  endtask

  // slow_clk level after n edges with a fixed offset: toggles every d+1 edges
  function automatic logic slow_at(input int n);
    return (n <= 0) ? 1'b0 : 1'(((n / (d + 1)) % 2));
  endfunction

  task automatic step(input logic [3:0] b);
    logic rise;
    btns = b;
    @(posedge clk);
    #1;
    m++;
    rise  = slow_at(m - 1) && !slow_at(m - 2);
    pulse = '0;
    if (rise)
      for (int i = 0; i < 4; i++) begin
        if (b2[i]) begin ones[i]++; zeros[i] = 0; end
        else begin zeros[i]++; ones[i] = 0; end
        if (ones[i] >= DB_LEN && !db[i]) begin db[i] = 1'b1; pulse[i] = 1'b1; end
        else if (zeros[i] >= DB_LEN) db[i] = 1'b0;
      end
    b2 = b1;
    b1 = b;
    if (btn_pulse[0]) pulses0++;
    check("slow_clk", 32'(slow_clk), 32'(slow_at(m)));
    check("disp_clk", 32'(disp_clk), 32'((m >> scan_sel) & 1));
    check("btn_pulse", 32'(btn_pulse), 32'(pulse[1:0]));
    check("btn_level", 32'(btn_level), 32'(db[3:2]));
  endtask

  task automatic do_reset(input int off);
    @(negedge clk);
    rst_n = 1'b0;
    btns = '0;
    d = off;
    div_offset = CNT_W'(off);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m = 0; b1 = '0; b2 = '0; db = '0; pulses0 = 0;
    for (int i = 0; i < 4; i++) begin ones[i] = 0; zeros[i] = DB_LEN; end
    check("reset_outputs", {26'd0, slow_clk, disp_clk, btn_pulse, btn_level}, 32'd0);
  endtask

  initial begin
    // Divider period 6 with a mid-count switch to offset 0
    scan_sel = 5'd2;
    do_reset(2);
    repeat (4) step(4'b0000);
    div_offset = '0;
    @(posedge clk); #1 check("switch_wrap", 32'(slow_clk), 32'd0);
    @(posedge clk); #1 check("fast_hi", 32'(slow_clk), 32'd1);
    @(posedge clk); #1 check("fast_lo", 32'(slow_clk), 32'd0);

    // Bouncy press on btns[0]: exactly one pulse, release gives none
    do_reset(2);
    scan_sel = 5'd3;
    repeat (6) step(4'b0001);
    repeat (6) step(4'b0000);
    repeat (60) step(4'b0001);
    check("press_pulse_count", 32'(pulses0), 32'd1);
    repeat (30) step(4'b0000);
    check("release_no_pulse", 32'(pulses0), 32'd1);

    // Level on btns[3] with a one-sample glitch
    repeat (30) step(4'b1000);
    check("level_set", 32'(btn_level[1]), 32'd1);
    repeat (6) step(4'b0000);
    repeat (6) step(4'b1000);
    check("level_glitch", 32'(btn_level[1]), 32'd1);
    repeat (30) step(4'b0000);
    check("level_clear", 32'(btn_level[1]), 32'd0);

    // Randomized bouncing on all four buttons at several divider settings
    for (int off = 0; off < 4; off++) begin
      logic [3:0] b;
      do_reset(off);
      scan_sel = 5'($urandom_range(0, 4));
      b = '0;
      for (int k = 0; k < 600; k++) begin
        for (int i = 0; i < 4; i++)
          if ($urandom_range(0, 4 * (off + 1)) == 0) b[i] = ~b[i];
        step(b);
      end
    end

    // Async reset while btn_level[0] is high clears outputs before any edge
    do_reset(1);
    repeat (40) step(4'b0100);
    check("pre_async_level", 32'(btn_level[0]), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {28'd0, slow_clk, disp_clk, btn_level}, 32'd0);
    check("async_reset_pulse", 32'(btn_pulse), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
